// File: rtl/gpu_instr_writer_if.sv
// -----------------------------------------------------------------------------
// gpu_instr_writer_if
//
// Purpose: groups the two buses that gpu_instr_writer sits between.
//   * Producer handshake: in_valid / in_ready / in_data_a / in_data_b.
//     A pair is transferred on a clock edge where in_valid and in_ready are
//     both high.
//   * GPU instruction-FIFO bus: data_a / data_b / wrreg / wrfull.
//     wrreg is a one-cycle write strobe qualifying data_a/data_b.
//     wrfull is the GPU-side back-pressure.
//
// Modports:
//   master : the outside world (producer plus GPU FIFO). Drives in_*, wrfull.
//            Observes in_ready, data_a, data_b, wrreg.
//   slave  : gpu_instr_writer itself.
// -----------------------------------------------------------------------------
interface gpu_instr_writer_if #(
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data_a;
  logic [DATA_W-1:0] in_data_b;

  logic              wrfull;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic              wrreg;

  modport master (
    output in_valid, in_data_a, in_data_b, wrfull,
    input  in_ready, data_a, data_b, wrreg
  );

  modport slave (
    input  in_valid, in_data_a, in_data_b, wrfull,
    output in_ready, data_a, data_b, wrreg
  );

endinterface

// File: rtl/gpu_instr_writer.sv
// -----------------------------------------------------------------------------
// gpu_instr_writer
//
// Purpose: bridges controller logic to the GPU instruction FIFO.
//   (data_a, data_b) pairs are buffered in an internal FIFO.
//   They are drained to the GPU as single-cycle wrreg pulses.
//   The drain honours wrfull and a minimum idle gap after every write.
//   With FRAME_SYNC=1, draining happens in batches, one per rising edge of
//   screen. Each batch is sized to the occupancy at the moment the batch
//   starts.
//   Every detected screen rising edge also produces a one-cycle
//   reset_pulsecounter pulse.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous active-high reset
//   bus (slave)         producer handshake plus GPU write bus
//                       (see gpu_instr_writer_if)
//   screen              GPU end-of-frame level (asynchronous, synchronised here)
//   reset_pulsecounter  one-cycle pulse per detected frame edge
//   level               current FIFO occupancy, 0..DEPTH
//   overflow            sticky: an offer was made while in_ready was low
//
// Parameters:
//   DATA_W      width of each instruction word
//   DEPTH       FIFO entries; power of two, 2..64
//   MIN_GAP     idle cycles after each wrreg pulse; 0..15
//   FRAME_SYNC  0 = free-running drain, 1 = frame-triggered batches
// -----------------------------------------------------------------------------
module gpu_instr_writer #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int MIN_GAP    = 1,
  parameter int FRAME_SYNC = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  gpu_instr_writer_if.slave      bus,
  input  logic                   screen,
  output logic                   reset_pulsecounter,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam bit FS = (FRAME_SYNC != 0);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LEVEL  = LW'(1);
  // gap_cnt counts down to zero, so it is loaded with MIN_GAP-1 on entry to
  // GAP. That gives exactly MIN_GAP cycles spent in GAP.
  localparam logic [3:0]    GAP_LOAD   = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    GAP        = 2'd2,
    WAIT_FRAME = 2'd3
  } state_t;

  // Storage and pointers.
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [2*DATA_W-1:0] head;
  logic                push;
  logic                pop;

  // Frame-edge detection.
  logic                scr_s1;
  logic                scr_s2;
  logic                scr_s3;
  logic                frame_edge;

  // Drain control.
  state_t              state;
  state_t              state_n;
  state_t              rest_state;
  logic [3:0]          gap_cnt;
  logic [3:0]          gap_n;
  logic [LW-1:0]       batch;
  logic [LW-1:0]       batch_n;
  logic                pending;
  logic                pending_n;
  logic                can_write;
  logic                more_now;
  logic                more_after_pop;

  // ---------------------------------------------------------------------------
  // Input side: push into the FIFO.
  // ---------------------------------------------------------------------------
  // in_ready depends only on registered occupancy. A full FIFO therefore
  // refuses a push even when a pop happens in the same cycle.
  assign bus.in_ready = (level < FULL_LEVEL);
  assign push         = bus.in_valid & bus.in_ready;
  assign head         = mem[rd_ptr];

  // The storage array carries no reset.
  // Entries are qualified by level, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_data_a, bus.in_data_b};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + ONE_LEVEL;
        2'b01:   level <= level - ONE_LEVEL;
        default: level <= level;
      endcase
      if (bus.in_valid && !bus.in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame edge: 2-flop synchroniser plus one delay flop for edge detection.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scr_s1             <= 1'b0;
      scr_s2             <= 1'b0;
      scr_s3             <= 1'b0;
      reset_pulsecounter <= 1'b0;
    end else begin
      scr_s1             <= screen;
      scr_s2             <= scr_s1;
      scr_s3             <= scr_s2;
      reset_pulsecounter <= frame_edge;
    end
  end

  assign frame_edge = scr_s2 & ~scr_s3;

  // ---------------------------------------------------------------------------
  // Drain FSM.
  // ---------------------------------------------------------------------------
  // When there is nothing more to write, free-running mode rests in IDLE.
  // Frame-synchronous mode rests in WAIT_FRAME.
  assign rest_state = FS ? WAIT_FRAME : IDLE;

  // In frame mode, only entries counted into the current batch may be
  // written. Later pushes wait for the next frame.
  assign can_write      = (level != '0) && !bus.wrfull && (!FS || (batch != '0));
  assign more_now       = FS ? (batch != '0)      : (level != '0);
  assign more_after_pop = FS ? (batch > ONE_LEVEL) : (level > ONE_LEVEL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= 4'd0;
      batch   <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
      batch   <= batch_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n   = state;
    gap_n     = gap_cnt;
    batch_n   = batch;
    pending_n = pending;
    pop       = 1'b0;

    // A frame edge that WAIT_FRAME cannot consume right now is remembered.
    // It is a single flag, so several edges during one batch collapse into
    // one follow-up batch.
    if (FS && frame_edge && (state != WAIT_FRAME)) begin
      pending_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (FS) begin
          state_n = WAIT_FRAME;
        end else if (level != '0) begin
          state_n = WRITE;
        end
      end

      WAIT_FRAME: begin
        if (frame_edge || pending) begin
          batch_n   = level;
          pending_n = 1'b0;
          if (level != '0) begin
            state_n = WRITE;
          end
        end
      end

      WRITE: begin
        if (can_write) begin
          pop = 1'b1;
          if (FS) begin
            batch_n = batch - ONE_LEVEL;
          end
          if (MIN_GAP > 0) begin
            state_n = GAP;
            gap_n   = GAP_LOAD;
          end else if (!more_after_pop) begin
            state_n = rest_state;
          end
        end else if (!more_now) begin
          state_n = rest_state;
        end
      end

      GAP: begin
        if (gap_cnt != 4'd0) begin
          gap_n = gap_cnt - 4'd1;
        end else begin
          state_n = more_now ? WRITE : rest_state;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // GPU write stage: registered strobe and data.
  // The data words are held until the next write.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.wrreg  <= 1'b0;
      bus.data_a <= '0;
      bus.data_b <= '0;
    end else begin
      bus.wrreg <= pop;
      if (pop) begin
        bus.data_a <= head[2*DATA_W-1:DATA_W];
        bus.data_b <= head[DATA_W-1:0];
      end
    end
  end

endmodule

// File: doc/gpu_instr_writer.md
Name: gpu_instr_writer

Overview:
Parametrised bridge between the soft-processor/controller logic and the graphics processor instruction FIFO. It buffers (data_a, data_b) instruction pairs in an internal FIFO and drains them to the GPU as single-cycle wrreg pulses, honouring wrfull and a minimum inter-write gap. An optional frame-synchronous mode releases each batch only on a screen (end-of-frame) rising edge. On every detected frame edge it also issues a one-cycle reset_pulsecounter pulse.

Parameters:
DATA_W, 32, width of each of data_a / data_b.
DEPTH, 8, internal FIFO entries; power of two, 2..64.
MIN_GAP, 1, idle cycles forced after each wrreg pulse; 0..15.
FRAME_SYNC, 0, 0 = free-running drain; 1 = drain only in batches triggered by screen rising edges.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  producer offers an instruction pair
in_ready  out  1  block can accept a pair this cycle
in_data_a  in  DATA_W  opcode/register word
in_data_b  in  DATA_W  operand word
wrfull  in  1  GPU instruction FIFO full
screen  in  1  GPU end-of-frame level; synchronised internally
data_a  out  DATA_W  word A to GPU
data_b  out  DATA_W  word B to GPU
wrreg  out  1  one-cycle GPU write strobe
reset_pulsecounter  out  1  one-cycle pulse per detected frame edge
level  out  clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: in_valid asserted while in_ready low; cleared only by reset

Behaviour:
- Reset (async assert, released synchronously): FIFO empty, level=0, data_a=data_b=0, wrreg=0, reset_pulsecounter=0, overflow=0, in_ready=1, FSM=IDLE, batch count=0, pending-frame flag=0. Reset mid-operation discards all buffered entries; no partial wrreg.
- Push: accepted when in_valid & in_ready. in_ready = (level < DEPTH). Full FIFO refuses a push even if a pop occurs in the same cycle. Simultaneous push+pop when not full: level unchanged.
- screen passes through a 2-flop synchroniser; rising edge detected on the synchronised signal (3-cycle edge-to-pulse latency). Each edge: reset_pulsecounter=1 for exactly one cycle.
- FSM states: IDLE, WRITE, GAP, (FRAME_SYNC=1 only) WAIT_FRAME.
- IDLE: FRAME_SYNC=0: go WRITE when level>0. FRAME_SYNC=1: go WAIT_FRAME.
- WAIT_FRAME: on frame edge (or pending-frame flag set), latch batch = current level (may be 0), clear flag; batch>0 -> WRITE, else stay.
- WRITE: when level>0 and wrfull=0 (sampled same cycle): pop head, register data_a/data_b, wrreg=1 next cycle; in FRAME_SYNC decrement batch. wrfull=1 -> stay, wrreg=0, nothing popped. data_a/data_b are held after the pulse until the next write.
- After a write: MIN_GAP>0 -> GAP for exactly MIN_GAP cycles; MIN_GAP=0 -> back-to-back writes permitted (wrreg can be high every cycle).
- GAP exit: FRAME_SYNC=0 -> WRITE if level>0 else IDLE; FRAME_SYNC=1 -> WRITE if batch>0 else WAIT_FRAME.
- Frame edge while batch>0: set pending-frame flag (single bit; additional edges merge); the next batch starts immediately when the current one ends. Entries pushed during a batch are never part of it.
- Latency, FRAME_SYNC=0, empty FIFO, wrfull=0: push accepted at cycle t -> wrreg high at t+2.
- level is updated on the cycle after push/pop. overflow sets on the cycle after the refused offer.

Test Plan:
- Reset, push 3 pairs (A=1,2,3; B=0x10,0x20,0x30), MIN_GAP=1, wrfull=0 -> wrreg pulses on alternating cycles, data_a order 1,2,3, level returns to 0.
- Fill DEPTH=8 with no drain (wrfull=1), offer a 9th -> in_ready=0 at level 8, overflow=1 sticky; release wrfull -> all 8 drain in order, in_ready=1 after first pop.
- wrfull toggled high during a 4-entry drain -> no wrreg while high, no entry lost or duplicated, order preserved.
- FRAME_SYNC=1: push 2, raise screen -> reset_pulsecounter one pulse, exactly 2 wrreg; push 2 more during the batch -> held until next screen edge.
- Two screen edges during a batch -> one pending batch only, two reset_pulsecounter pulses; MIN_GAP=0 -> wrreg high on consecutive cycles.
- Assert reset with 5 entries buffered mid-drain -> wrreg=0, level=0, data_a=data_b=0 immediately; no writes after release.
